// File: rtl/axis_pkg.sv
// Shared definitions for the classifier stream wrapper and its image source.
// Holds the clogb2 sizing helper, the one-hot FSM state encoding and the
// default width/depth constants.
package axis_pkg;

  localparam int unsigned DefDataWidth          = 32;
  localparam int unsigned DefOutWidth           = 4;
  localparam int unsigned DefNumberOfInputWords = 32;

  // One-hot encoding, same style as the wrapper FSM.
  typedef enum logic [3:0] {
    StIdle       = 4'b0001,
    StSend       = 4'b0010,
    StWaitResult = 4'b0100,
    StDone       = 4'b1000
  } state_e;

  // Number of bits needed to represent the value depth (0 for depth 0).
  function automatic int unsigned clogb2(input int unsigned depth);
    int unsigned d;
    int unsigned r;
    d = depth;
    r = 0;
    while (d > 0) begin
      r++;
      d = d >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_frame_buf.sv
// Frame buffer for the image source: register array with one synchronous write
// port and one combinational indexed read port.
// Ports:
//   clk_i     - clock
//   wr_en_i   - write strobe, ignored while busy_i is high
//   wr_addr_i - write address
//   wr_data_i - write data
//   busy_i    - frame in flight; blocks writes so a frame cannot change mid-send
//   rd_addr_i - read address
//   rd_data_o - read data (0 for out-of-range addresses)
module axis_frame_buf #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned NUMBER_OF_INPUT_WORDS = 32,
  parameter int unsigned AW                    = 5
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  busy_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  // Contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [NUMBER_OF_INPUT_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_i && (32'(wr_addr_i) < NUMBER_OF_INPUT_WORDS)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (32'(rd_addr_i) < NUMBER_OF_INPUT_WORDS) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/axis_img_source.sv
// AXI4-Stream image source. A preloaded frame is streamed on the master port
// with tlast on the final word; the single result beat is then taken from the
// slave port and latched, or a timeout error is pulsed.
// Ports:
//   axi_clk, axi_reset_n              - clock, async active-low reset
//   mem_wr_en/addr/data               - frame buffer write port (blocked while busy)
//   start, frame_len                  - send request and length (0 or >N means N)
//   busy                              - high outside IDLE
//   m_axis_valid/data/last/ready      - image stream out
//   s_axis_valid/data/last/ready      - result stream in
//   result, done, timeout_err         - captured result, done pulse, timeout pulse
module axis_img_source
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = DefDataWidth,
  parameter int unsigned OUT_WIDTH             = DefOutWidth,
  parameter int unsigned NUMBER_OF_INPUT_WORDS = DefNumberOfInputWords,
  parameter int unsigned TIMEOUT_CYCLES        = 1024,
  localparam int unsigned AW = clogb2(NUMBER_OF_INPUT_WORDS - 1),
  localparam int unsigned LW = AW + 1
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic                  mem_wr_en,
  input  logic [AW-1:0]         mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  start,
  input  logic [LW-1:0]         frame_len,
  output logic                  busy,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  input  logic                  s_axis_valid,
  input  logic [OUT_WIDTH-1:0]  s_axis_data,
  input  logic                  s_axis_last,
  output logic                  s_axis_ready,
  output logic [OUT_WIDTH-1:0]  result,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int unsigned TW = clogb2(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [OUT_WIDTH-1:0]  result_q, result_d;
  logic                  tmo_err_q, tmo_err_d;

  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // The result stream carries a single beat, so its tlast carries no information.
  logic unused_s_last;
  assign unused_s_last = s_axis_last;

  assign busy = (state_q != StIdle);

  // In IDLE word 0 is prefetched; in SEND the word after the current one.
  assign rd_addr = (state_q == StSend) ? rd_ptr_q + AW'(1) : '0;

  axis_frame_buf #(
    .DATA_WIDTH            (DATA_WIDTH),
    .NUMBER_OF_INPUT_WORDS (NUMBER_OF_INPUT_WORDS),
    .AW                    (AW)
  ) u_frame_buf (
    .clk_i     (axi_clk),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (mem_wr_addr),
    .wr_data_i (mem_wr_data),
    .busy_i    (busy),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    result_d  = result_q;
    tmo_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d = (frame_len == '0 || frame_len > LW'(NUMBER_OF_INPUT_WORDS)) ?
                  LW'(NUMBER_OF_INPUT_WORDS) : frame_len;
          data_d   = rd_data;
          valid_d  = 1'b1;
          last_d   = (len_d == LW'(1));
          rd_ptr_d = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (valid_q && m_axis_ready) begin
          if ({1'b0, rd_ptr_q} < len_q - LW'(1)) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            data_d   = rd_data;
            last_d   = ({1'b0, rd_ptr_q} + LW'(1) == len_q - LW'(1));
          end else begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            data_d   = '0;
            rd_ptr_d = '0;
            tmo_d    = '0;
            state_d  = StWaitResult;
          end
        end
      end
      StWaitResult: begin
        // A result on the timeout cycle takes priority over the error.
        if (s_axis_valid) begin
          result_d = s_axis_data;
          tmo_d    = '0;
          state_d  = StDone;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_err_d = 1'b1;
          tmo_d     = '0;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= StIdle;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      tmo_q     <= '0;
      result_q  <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      len_q     <= len_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      result_q  <= result_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign m_axis_valid = valid_q;
  assign m_axis_data  = data_q;
  assign m_axis_last  = last_q;
  assign s_axis_ready = (state_q == StWaitResult);
  assign result       = result_q;
  assign done         = (state_q == StDone);
  assign timeout_err  = tmo_err_q;

endmodule

// File: doc/axis_img_source.md
Name: axis_img_source

Overview:
- AXI4-Stream image source. It is the initiator side of the classifier stream wrapper.
- A host or bench preloads one frame of image words into an internal buffer, then pulses start.
- The block streams the frame out on a master AXI4-S port, with tlast on the final word.
- It then accepts the classifier's single result beat on a slave AXI4-S port, latches it, and reports done, or reports a timeout error.

Parameters:
- DATA_WIDTH, 32: width of each streamed image word.
- OUT_WIDTH, 4: width of the captured classification result.
- NUMBER_OF_INPUT_WORDS, 32: depth of the frame buffer and maximum frame length.
- TIMEOUT_CYCLES, 1024: maximum number of WAIT_RESULT cycles before an error is flagged.
- Derived: AW = clogb2(NUMBER_OF_INPUT_WORDS-1); LW = AW+1.

Ports:
- axi_clk, in, 1: single clock.
- axi_reset_n, in, 1: asynchronous active-low reset.
- mem_wr_en, in, 1: frame buffer write strobe.
- mem_wr_addr, in, AW: frame buffer write address.
- mem_wr_data, in, DATA_WIDTH: frame buffer write data.
- start, in, 1: single-cycle request to send one frame.
- frame_len, in, LW: number of words to send; sampled on an accepted start.
- busy, out, 1: high in every state except IDLE.
- m_axis_valid, out, 1: image stream valid.
- m_axis_data, out, DATA_WIDTH: image word.
- m_axis_last, out, 1: final word of the frame.
- m_axis_ready, in, 1: downstream ready.
- s_axis_valid, in, 1: result valid.
- s_axis_data, in, OUT_WIDTH: result value.
- s_axis_last, in, 1: result last; accepted but not required.
- s_axis_ready, out, 1: ready for the result.
- result, out, OUT_WIDTH: last captured result.
- done, out, 1: one-cycle pulse when a result is captured.
- timeout_err, out, 1: one-cycle pulse on timeout.

Behaviour:
- Reset (async assert, sync deassert):
  - State goes to IDLE.
  - All outputs are 0, including result.
  - Read pointer, length and timeout counters clear.
  - Frame buffer contents are not reset.
  - Reset mid-frame drops m_axis_valid immediately; no partial-frame recovery.
- States:
  - IDLE. On start: latch len = (frame_len==0 || frame_len>N) ? N : frame_len. Register word 0 into m_axis_data. Set m_axis_valid=1, and m_axis_last=(len==1). Go to SEND. The first beat is visible the cycle after start.
  - SEND. On a handshake (m_axis_valid & m_axis_ready):
    - If rd_ptr < len-1: increment rd_ptr, load mem[rd_ptr+1] into m_axis_data, set m_axis_last=(rd_ptr+1 == len-1), keep valid=1. Sustained throughput is one word per clock.
    - If rd_ptr == len-1: clear valid and last, clear rd_ptr, and go to WAIT_RESULT.
  - WAIT_RESULT. s_axis_ready=1 combinationally while in this state. The timeout counter increments every cycle.
    - On s_axis_valid: result <= s_axis_data, done pulses 1 the next cycle, go to DONE.
    - If the counter reaches TIMEOUT_CYCLES-1 with no result: timeout_err pulses 1, result is unchanged, go to IDLE.
    - If a result arrives on the same cycle the timeout would fire, the result wins.
  - DONE. Lasts one cycle, in which done=1. Return to IDLE.
- AXI-S source rules:
  - While valid=1 and ready=0, m_axis_data and m_axis_last hold stable.
  - Valid never drops without a handshake, except on reset.
  - m_axis_data is 0 whenever valid=0.
- Frame buffer:
  - Register array of N × DATA_WIDTH, written synchronously.
  - mem_wr_en is ignored while busy=1, so a frame cannot be modified mid-send.
- start while busy=1 is ignored (no queueing).
- start and mem_wr_en on the same IDLE cycle: the write commits, and word 0 sent is the pre-write value.
- s_axis_valid outside WAIT_RESULT is not accepted (ready=0) and is not captured.
- The back-to-back frame minimum gap is IDLE→start; start in the DONE cycle is ignored.

Decomposition:
- Shared package, axis_pkg:
  - clogb2 function.
  - State encoding (IDLE=4'b0001, SEND=4'b0010, WAIT_RESULT=4'b0100, DONE=4'b1000), matching the one-hot style of the wrapper FSM.
  - Default DATA_WIDTH, OUT_WIDTH and NUMBER_OF_INPUT_WORDS constants, shared with the wrapper.
- One sub-module, axis_frame_buf: the write port plus the indexed read, with the busy write-block.
- FSM, the output register and the timeout counter stay in the top module.

Test Plan:
1. Load words 0x00000000..0x0000001F, set frame_len=0, pulse start, hold m_axis_ready=1. Expect exactly 32 beats on consecutive cycles with data = index, m_axis_last only on beat 31. Then return s_axis_data=4'h7: result=7 and done pulses once.
2. Same frame with m_axis_ready toggling 1,0,0,1,… Expect data and last stable during stalls, 32 beats in order, no duplicates.
3. frame_len=5: expect beats 0..4 with last on beat 4. frame_len=40: expect clamping to 32 beats.
4. Send a frame and never assert s_axis_valid. Expect timeout_err to pulse exactly 1024 cycles after entering WAIT_RESULT, result to keep its previous value, and busy to fall.
5. Pulse start and mem_wr_en (addr 3, data 0xDEAD) mid-SEND. Expect no second frame, and beat 3 to carry the original value.
6. Assert axi_reset_n low on beat 10. Expect m_axis_valid=0 asynchronously, state IDLE, result=0. A subsequent start sends the full frame from beat 0.
